// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the signals of the shared memory port arbiter. The arbiter owns the
// outputs and uses the slave modport. The pipeline stages and the memory
// (or a testbench standing in for them) use the master modport.
//   IF side   : if_req, if_addr -> if_rdata, if_ready, stall_if
//   MEM side  : mem_rd, mem_wr, mem_addr, mem_wdata -> mem_rdata, mem_ready, stall_mem
//   Bus side  : bus_req, bus_we, bus_addr, bus_wdata, bus_err -> bus_rdata, bus_ack
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, bus_rdata, bus_ack,
    output if_rdata, if_ready, mem_rdata, mem_ready, stall_if, stall_mem,
           bus_req, bus_we, bus_addr, bus_wdata, bus_err
  );

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, bus_rdata, bus_ack,
    input  if_rdata, if_ready, mem_rdata, mem_ready, stall_if, stall_mem,
           bus_req, bus_we, bus_addr, bus_wdata, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one external memory port between instruction fetch and the MEM-stage
// load/store. A request is sampled in IDLE, the winner is latched onto the bus
// with a registered req/ack handshake, and a one-cycle ready pulse is returned
// in RESP. MEM wins ties, except that IF is forced through after
// MAX_MEM_STREAK consecutive MEM grants made while IF was waiting.
// Ports:
//   clk     : single clock, rising edge
//   reset   : asynchronous, active-low
//   port_if : mem_port_arbiter_if.slave (requesters, stalls and memory bus)
// Parameters:
//   MAX_MEM_STREAK : MEM grants allowed while IF waits (1..15)
//   TIMEOUT_CYCLES : bus wait limit in cycles (1..65535), timeout build only
// Build option:
//   ARB_TIMEOUT_EN : when defined, an unanswered access is abandoned after
//                    TIMEOUT_CYCLES bus_req cycles. The requester gets ready
//                    with zero read data, and bus_err pulses. When undefined,
//                    the arbiter waits forever and bus_err is tied to 0.
module mem_port_arbiter #(
  parameter int unsigned MAX_MEM_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic            clk,
  input logic            reset,
  mem_port_arbiter_if.slave port_if
);

  if (MAX_MEM_STREAK < 1 || MAX_MEM_STREAK > 15 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_range
    $error("mem_port_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_IF  = 2'd1,
    GRANT_MEM = 2'd2,
    RESP      = 2'd3
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_MEM_STREAK);

  state_t      state_r;
  logic [3:0]  streak_r;
  logic        bus_req_r;
  logic        bus_we_r;
  logic [31:0] bus_addr_r;
  logic [31:0] bus_wdata_r;
  logic [31:0] if_rdata_r;
  logic [31:0] mem_rdata_r;
  logic        if_ready_r;
  logic        mem_ready_r;

  logic        mem_req_s;
  logic        force_if_s;
  logic        timeout_s;

  assign mem_req_s  = port_if.mem_rd | port_if.mem_wr;
  // IF is forced once MEM has won STREAK_MAX times in a row against a waiting IF.
  assign force_if_s = port_if.if_req & (streak_r == STREAK_MAX);

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_r;
  logic        bus_err_r;
  // The counter holds (cycles waited - 1), so the compare hits on the last allowed cycle.
  assign timeout_s       = (to_cnt_r == TIMEOUT_LAST);
  assign port_if.bus_err = bus_err_r;
`else
  assign timeout_s       = 1'b0;
  assign port_if.bus_err = 1'b0;
`endif

  // Arbitration FSM, bus handshake and registered requester outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      streak_r    <= 4'd0;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 32'd0;
      bus_wdata_r <= 32'd0;
      if_rdata_r  <= 32'd0;
      mem_rdata_r <= 32'd0;
      if_ready_r  <= 1'b0;
      mem_ready_r <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      to_cnt_r    <= 16'd0;
      bus_err_r   <= 1'b0;
`endif
    end else begin
      // Ready and error are single-cycle pulses; only the ack/timeout edge sets them.
      if_ready_r  <= 1'b0;
      mem_ready_r <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      bus_err_r   <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (mem_req_s && !force_if_s) begin
            state_r     <= GRANT_MEM;
            bus_req_r   <= 1'b1;
            bus_we_r    <= port_if.mem_wr;  // rd and wr together behave as a store
            bus_addr_r  <= port_if.mem_addr;
            bus_wdata_r <= port_if.mem_wdata;
            streak_r    <= port_if.if_req ? (streak_r + 4'd1) : 4'd0;
`ifdef ARB_TIMEOUT_EN
            to_cnt_r    <= 16'd0;
`endif
          end else if (port_if.if_req) begin
            state_r     <= GRANT_IF;
            bus_req_r   <= 1'b1;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= port_if.if_addr;
            bus_wdata_r <= 32'd0;
            streak_r    <= 4'd0;
`ifdef ARB_TIMEOUT_EN
            to_cnt_r    <= 16'd0;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT_IF, GRANT_MEM: begin
          if (port_if.bus_ack) begin
            // Ack wins over a coinciding timeout.
            bus_req_r <= 1'b0;
            state_r   <= RESP;
            if (state_r == GRANT_IF) begin
              if_rdata_r <= port_if.bus_rdata;
              if_ready_r <= 1'b1;
            end else begin
              mem_ready_r <= 1'b1;
              if (!bus_we_r) begin
                mem_rdata_r <= port_if.bus_rdata;
              end else begin
                mem_rdata_r <= mem_rdata_r;
              end
            end
          end else if (timeout_s) begin
            bus_req_r <= 1'b0;
            state_r   <= RESP;
`ifdef ARB_TIMEOUT_EN
            bus_err_r <= 1'b1;
`endif
            if (state_r == GRANT_IF) begin
              if_rdata_r <= 32'd0;
              if_ready_r <= 1'b1;
            end else begin
              mem_ready_r <= 1'b1;
              if (!bus_we_r) begin
                mem_rdata_r <= 32'd0;
              end else begin
                mem_rdata_r <= mem_rdata_r;
              end
            end
          end else begin
            state_r <= state_r;
`ifdef ARB_TIMEOUT_EN
            to_cnt_r <= to_cnt_r + 16'd1;
`endif
          end
        end
        // One dead cycle lets the completed requester drop its request before re-arbitration.
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          bus_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign port_if.bus_req   = bus_req_r;
  assign port_if.bus_we    = bus_we_r;
  assign port_if.bus_addr  = bus_addr_r;
  assign port_if.bus_wdata = bus_wdata_r;
  assign port_if.if_rdata  = if_rdata_r;
  assign port_if.mem_rdata = mem_rdata_r;
  assign port_if.if_ready  = if_ready_r;
  assign port_if.mem_ready = mem_ready_r;
  assign port_if.stall_if  = port_if.if_req & ~if_ready_r;
  assign port_if.stall_mem = mem_req_s & ~mem_ready_r;

endmodule
